// File: rtl/data_memory_master_if.sv
// data_memory_master_if: request, store-data, load-response and memory-port signals of the data memory controller.
interface data_memory_master_if #(parameter int ADDR_W = 10, parameter int DATA_W = 18, parameter int LEN_W = 3);
  logic req_valid, req_ready, req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0] req_len;
  logic wr_valid, wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic rd_valid, rd_last, rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic busy, err;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_input, mem_data_output;
  logic mem_str;
  modport master (
    input req_valid, req_write, req_addr, req_len, wr_valid, wr_data, rd_ready, mem_data_output,
    output req_ready, wr_ready, rd_valid, rd_data, rd_last, busy, err, mem_address, mem_data_input, mem_str
  );
  modport slave (
    output req_valid, req_write, req_addr, req_len, wr_valid, wr_data, rd_ready, mem_data_output,
    input req_ready, wr_ready, rd_valid, rd_data, rd_last, busy, err, mem_address, mem_data_input, mem_str
  );
endinterface

// File: rtl/data_memory_master.sv
// data_memory_master: burst load/store sequencer for the 1024x18 synchronous data memory.
// Define DATA_MEMORY_MASTER_BOUNDS_EN to reject bursts that would run past the top address.
module data_memory_master #(parameter int ADDR_W = 10, parameter int DATA_W = 18, parameter int LEN_W = 3) (
  input logic clock,
  input logic reset_n,
  data_memory_master_if.master bus
);
  typedef enum logic [2:0] {IDLE, WRITE, READ_ADDR, READ_WAIT, READ_RESP} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic err_q, err_d, oob, last;
`ifdef DATA_MEMORY_MASTER_BOUNDS_EN
  logic [ADDR_W:0] end_addr;
  assign end_addr = {1'b0, bus.req_addr} + {{(ADDR_W+1-LEN_W){1'b0}}, bus.req_len};
  assign oob = end_addr[ADDR_W];
`else
  assign oob = 1'b0;
`endif
  assign last = cnt_q == len_q;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q <= '0;
      len_q <= '0;
      cnt_q <= '0;
      rd_data_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      rd_data_q <= rd_data_d;
      err_q <= err_d;
    end
  end
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    len_d = len_q;
    cnt_d = cnt_q;
    rd_data_d = rd_data_q;
    err_d = 1'b0;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        addr_d = bus.req_addr;
        len_d = bus.req_len;
        cnt_d = '0;
        err_d = oob;
        state_d = oob ? IDLE : bus.req_write ? WRITE : READ_ADDR;
      end
      WRITE: if (bus.wr_valid) begin
        addr_d = addr_q + 1'b1;
        cnt_d = cnt_q + 1'b1;
        state_d = last ? IDLE : WRITE;
      end
      READ_ADDR: state_d = READ_WAIT;
      READ_WAIT: begin
        rd_data_d = bus.mem_data_output;
        state_d = READ_RESP;
      end
      READ_RESP: if (bus.rd_ready) begin
        addr_d = last ? addr_q : addr_q + 1'b1;
        cnt_d = last ? cnt_q : cnt_q + 1'b1;
        state_d = last ? IDLE : READ_ADDR;
      end
      default: state_d = IDLE;
    endcase
  end
  // Strobe is decoded from state so an async reset kills it without waiting for a clock
  assign bus.req_ready = state_q == IDLE;
  assign bus.busy = state_q != IDLE;
  assign bus.wr_ready = state_q == WRITE;
  assign bus.mem_str = bus.wr_ready && bus.wr_valid;
  assign bus.mem_data_input = bus.wr_data;
  assign bus.mem_address = addr_q;
  assign bus.rd_valid = state_q == READ_RESP;
  assign bus.rd_last = bus.rd_valid && last;
  assign bus.rd_data = rd_data_q;
  assign bus.err = err_q;
endmodule

// File: tb/tb_data_memory_master.sv
// tb_data_memory_master: scoreboard bench for data_memory_master with a behavioural synchronous memory.
module tb_data_memory_master;
  logic clock = 1'b0;
  logic rst_n = 1'b0;
  always #5 clock = ~clock;
  data_memory_master_if bus ();
  data_memory_master dut (.clock(clock), .reset_n(rst_n), .bus(bus));
  logic [17:0] mem [1024];
  logic [17:0] gold [1024];
  logic [17:0] mem_q;
  logic [27:0] exp_w [$];
  logic [27:0] act_w [$];
  logic [18:0] exp_r [$];
  int errs = 0;
  int checks = 0;
  assign bus.mem_data_output = mem_q;
  always @(posedge clock) begin
    if (bus.mem_str) begin
      mem[bus.mem_address] <= bus.mem_data_input;
      act_w.push_back({bus.mem_address, bus.mem_data_input});
    end
    mem_q <= mem[bus.mem_address];
  end
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic do_store(input logic [9:0] a, input int n, input logic [17:0] d [8], input int gap_at, input int gap_len, input int abort_at);
    logic [27:0] e, o;
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = a; bus.req_len = 3'(n - 1); bus.wr_valid = 1'b0;
    tick;
    bus.req_valid = 1'b0;
    checks++; if (bus.wr_ready !== 1'b1 || bus.err !== 1'b0) begin errs++; $display("FAIL st_accept: wr_ready=%b err=%b want 1/0", bus.wr_ready, bus.err); end
    for (int b = 0; b < n; b++) begin
      if (b == abort_at) begin
        bus.wr_valid = 1'b1; bus.wr_data = d[b];
        rst_n = 1'b0;
        #1;
        checks++; if ({bus.mem_str, bus.busy, bus.req_ready, bus.wr_ready, bus.mem_address} !== {4'b0010, 10'h0}) begin errs++; $display("FAIL st_abort: str/busy/rdy/wrdy=%b%b%b%b addr=%h want 0010 000", bus.mem_str, bus.busy, bus.req_ready, bus.wr_ready, bus.mem_address); end
        tick; tick;
        rst_n = 1'b1; bus.wr_valid = 1'b0;
        tick;
        break;
      end
      if (b == gap_at) repeat (gap_len) begin
        bus.wr_valid = 1'b0;
        #1;
        checks++; if (bus.mem_str !== 1'b0 || bus.wr_ready !== 1'b1) begin errs++; $display("FAIL st_gap: mem_str=%b wr_ready=%b want 0/1", bus.mem_str, bus.wr_ready); end
        tick;
      end
      bus.wr_valid = 1'b1; bus.wr_data = d[b];
      #1;
      exp_w.push_back({10'(a + b), d[b]});
      gold[10'(a + b)] = d[b];
      checks++; if (bus.mem_str !== 1'b1 || bus.mem_address !== 10'(a + b)) begin errs++; $display("FAIL st_beat %0d: str=%b addr=%h want 1 %h", b, bus.mem_str, bus.mem_address, 10'(a + b)); end
      tick;
    end
    bus.wr_valid = 1'b0;
    #1;
    checks++; if ({bus.req_ready, bus.busy, bus.mem_str} !== 3'b100) begin errs++; $display("FAIL st_done: rdy/busy/str=%b want 100", {bus.req_ready, bus.busy, bus.mem_str}); end
    checks++; if (act_w.size() != exp_w.size()) begin errs++; $display("FAIL st_count: got %0d writes want %0d", act_w.size(), exp_w.size()); end
    while (exp_w.size() > 0 && act_w.size() > 0) begin
      e = exp_w.pop_front(); o = act_w.pop_front();
      checks++; if (o !== e) begin errs++; $display("FAIL st_write: got addr %h data %h want addr %h data %h", o[27:18], o[17:0], e[27:18], e[17:0]); end
    end
    exp_w.delete(); act_w.delete();
  endtask
  task automatic do_load(input logic [9:0] a, input int n, input int stall_beat, input int stall_len, input bit hold_req);
    logic [17:0] d0;
    logic [9:0] a0;
    logic [18:0] e;
    int k;
    for (int i = 0; i < n; i++) exp_r.push_back({i == n - 1, gold[10'(a + i)]});
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = a; bus.req_len = 3'(n - 1); bus.rd_ready = 1'b0;
    tick;
    if (hold_req) bus.req_write = 1'b1; else bus.req_valid = 1'b0;
    for (int b = 0; b < n; b++) begin
      k = 0;
      while (!bus.rd_valid && k < 8) begin
        checks++; if (bus.req_ready !== 1'b0 || bus.busy !== 1'b1 || bus.mem_str !== 1'b0) begin errs++; $display("FAIL ld_busy: rdy=%b busy=%b str=%b want 0 1 0", bus.req_ready, bus.busy, bus.mem_str); end
        tick; k++;
      end
      checks++; if (k != 2) begin errs++; $display("FAIL ld_latency beat %0d: rd_valid after %0d extra cycles want 2", b, k); end
      if (b == stall_beat) begin
        d0 = bus.rd_data; a0 = bus.mem_address;
        repeat (stall_len) begin
          tick;
          checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== d0 || bus.mem_address !== a0 || bus.req_ready !== 1'b0) begin errs++; $display("FAIL ld_stall: valid=%b data=%h addr=%h rdy=%b want 1 %h %h 0", bus.rd_valid, bus.rd_data, bus.mem_address, bus.req_ready, d0, a0); end
        end
      end
      if (b == n - 1) bus.req_valid = 1'b0;
      bus.rd_ready = 1'b1;
      e = exp_r.size() > 0 ? exp_r.pop_front() : '1;
      checks++; if ({bus.rd_last, bus.rd_data} !== e) begin errs++; $display("FAIL ld_beat %0d: last=%b data=%h want last=%b data=%h", b, bus.rd_last, bus.rd_data, e[18], e[17:0]); end
      tick;
      bus.rd_ready = 1'b0;
    end
    checks++; if ({bus.req_ready, bus.busy, bus.rd_valid, bus.wr_ready} !== 4'b1000) begin errs++; $display("FAIL ld_done: rdy/busy/valid/wrdy=%b want 1000", {bus.req_ready, bus.busy, bus.rd_valid, bus.wr_ready}); end
    checks++; if (exp_r.size() != 0) begin errs++; $display("FAIL ld_pending: %0d beats undelivered want 0", exp_r.size()); end
    exp_r.delete();
  endtask
  task automatic test_reset;
    #1;
    checks++; if ({bus.req_ready, bus.wr_ready, bus.rd_valid, bus.rd_last, bus.busy, bus.err, bus.mem_str} !== 7'b1000000 || bus.rd_data !== 18'h0 || bus.mem_address !== 10'h0) begin errs++; $display("FAIL reset_vals: flags=%b rd_data=%h addr=%h want 1000000 0 0", {bus.req_ready, bus.wr_ready, bus.rd_valid, bus.rd_last, bus.busy, bus.err, bus.mem_str}, bus.rd_data, bus.mem_address); end
    tick; tick;
    rst_n = 1'b1;
    tick;
  endtask
  task automatic test_single;
    logic [17:0] d [8];
    d = '{18'h2AAAA, 0, 0, 0, 0, 0, 0, 0};
    do_store(10'h000, 1, d, -1, 0, -1);
    do_load(10'h000, 1, -1, 0, 1'b0);
  endtask
  task automatic test_wrap_gap;
    logic [17:0] d [8];
    d = '{18'd1, 18'd2, 18'd3, 18'd4, 0, 0, 0, 0};
    do_store(10'h3FE, 4, d, 2, 2, -1);
    do_load(10'h3FE, 4, -1, 0, 1'b0);
  endtask
  task automatic test_stall;
    do_load(10'h3FF, 3, 1, 5, 1'b0);
  endtask
  task automatic test_reset_mid;
    logic [17:0] d [8];
    d = '{18'h1F00D, 18'h2BEEF, 18'h0CAFE, 18'h3ACE5, 0, 0, 0, 0};
    do_store(10'h100, 4, d, -1, 0, 1);
    do_load(10'h100, 4, -1, 0, 1'b0);
  endtask
  task automatic test_hold_req;
    do_load(10'h0F0, 4, 2, 1, 1'b1);
  endtask
  task automatic test_bounds;
`ifdef DATA_MEMORY_MASTER_BOUNDS_EN
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 10'h3FE; bus.req_len = 3'd3;
    bus.wr_valid = 1'b1; bus.wr_data = 18'h15555;
    #1;
    checks++; if (bus.req_ready !== 1'b1) begin errs++; $display("FAIL oob_ready: req_ready=%b want 1", bus.req_ready); end
    tick;
    bus.req_valid = 1'b0;
    checks++; if ({bus.err, bus.busy, bus.wr_ready, bus.mem_str} !== 4'b1000) begin errs++; $display("FAIL oob_pulse: err/busy/wrdy/str=%b want 1000", {bus.err, bus.busy, bus.wr_ready, bus.mem_str}); end
    tick;
    bus.wr_valid = 1'b0;
    checks++; if ({bus.err, bus.busy} !== 2'b00) begin errs++; $display("FAIL oob_clear: err/busy=%b want 00", {bus.err, bus.busy}); end
    checks++; if (act_w.size() != 0) begin errs++; $display("FAIL oob_writes: got %0d writes want 0", act_w.size()); end
    act_w.delete();
    do_load(10'h3FE, 4, -1, 0, 1'b0);
`else
    logic [17:0] d [8];
    d = '{18'h11, 18'h22, 18'h33, 18'h44, 0, 0, 0, 0};
    do_store(10'h3FE, 4, d, -1, 0, -1);
    checks++; if (bus.err !== 1'b0) begin errs++; $display("FAIL wrap_err: err=%b want 0", bus.err); end
    do_load(10'h3FE, 4, -1, 0, 1'b0);
`endif
  endtask
  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 18'(i * 7 + 5);
      gold[i] = 18'(i * 7 + 5);
    end
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_len = '0;
    bus.wr_valid = 1'b0; bus.wr_data = '0; bus.rd_ready = 1'b0;
    test_reset;
    test_single;
    test_wrap_gap;
    test_stall;
    test_reset_mid;
    test_hold_req;
    test_bounds;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
